y86_pipe_reg: RTL

Parametrised Y86 pipeline stage register that replaces the per-stage hand-written registers (F/D/E/M/W) with one block. It captures a stage's instruction fields on every clock and supports normal load, stall (hold), bubble (inject nop) and synchronous reset with a defined priority. It also keeps saturating stall and bubble event counters and a sticky control-conflict flag for the hazard unit and the testbench.

---
 rtl/y86_pipe_reg.sv | 108 ++++++++++
 1 files changed

// File: rtl/y86_pipe_reg.sv
// Y86 pipeline stage register: one reusable block for the F/D/E/M/W
// boundaries. Supports load, stall (hold), bubble (nop injection) and
// synchronous reset, plus saturating stall/bubble event counters and a
// sticky flag for a stall+bubble control conflict.
module y86_pipe_reg #(
    parameter int          DATA_W    = 192,
    parameter int          CNT_W     = 16,
    parameter logic [3:0]  NOP_ICODE = 4'h1,
    parameter logic [3:0]  SAOK      = 4'h1,
    parameter logic [3:0]  RNONE     = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_stall,
    input  logic              in_bubble,
    input  logic              clr_cnt,
    input  logic [3:0]        d_stat,
    input  logic [3:0]        d_icode,
    input  logic [3:0]        d_ifun,
    input  logic [DATA_W-1:0] d_payload,
    input  logic [3:0]        d_dstE,
    input  logic [3:0]        d_dstM,
    output logic [3:0]        q_stat,
    output logic [3:0]        q_icode,
    output logic [3:0]        q_ifun,
    output logic [DATA_W-1:0] q_payload,
    output logic [3:0]        q_dstE,
    output logic [3:0]        q_dstM,
    output logic              q_valid,
    output logic              ctl_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Saturating increment: all-ones sticks instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [3:0]        stat_p0;
    logic [3:0]        icode_p0;
    logic [3:0]        ifun_p0;
    logic [DATA_W-1:0] payload_p0;
    logic [3:0]        dste_p0;
    logic [3:0]        dstm_p0;
    logic              vld_p0;
    logic              ctl_err_p0;
    logic [CNT_W-1:0]  stall_cnt_p0;
    logic [CNT_W-1:0]  bubble_cnt_p0;

    // Stage register: reset or bubble loads the full nop image, stall holds,
    // otherwise every field is captured from the incoming stage.
    always_ff @(posedge clk) begin
        if (reset || in_bubble) begin
            stat_p0    <= SAOK;
            icode_p0   <= NOP_ICODE;
            ifun_p0    <= 4'h0;
            payload_p0 <= '0;
            dste_p0    <= RNONE;
            dstm_p0    <= RNONE;
            vld_p0     <= 1'b0;
        end else if (!in_stall) begin
            stat_p0    <= d_stat;
            icode_p0   <= d_icode;
            ifun_p0    <= d_ifun;
            payload_p0 <= d_payload;
            dste_p0    <= d_dstE;
            dstm_p0    <= d_dstM;
            vld_p0     <= 1'b1;
        end
    end

    // Sticky conflict flag: a simultaneous stall and bubble request is a
    // hazard-unit bug; only reset clears the record of it.
    always_ff @(posedge clk) begin
        if (reset)
            ctl_err_p0 <= 1'b0;
        else if (in_bubble && in_stall)
            ctl_err_p0 <= 1'b1;
    end

    // Event counters follow the same priority as the stage register: a
    // bubble cycle is never also counted as a stall. clr_cnt beats increments.
    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            stall_cnt_p0  <= '0;
            bubble_cnt_p0 <= '0;
        end else if (in_bubble) begin
            bubble_cnt_p0 <= sat_inc(bubble_cnt_p0);
        end else if (in_stall) begin
            stall_cnt_p0  <= sat_inc(stall_cnt_p0);
        end
    end

    assign q_stat     = stat_p0;
    assign q_icode    = icode_p0;
    assign q_ifun     = ifun_p0;
    assign q_payload  = payload_p0;
    assign q_dstE     = dste_p0;
    assign q_dstM     = dstm_p0;
    assign q_valid    = vld_p0;
    assign ctl_err    = ctl_err_p0;
    assign stall_cnt  = stall_cnt_p0;
    assign bubble_cnt = bubble_cnt_p0;

endmodule
